ram_arbiter_rr: RTL and testbench

Two-port round-robin arbiter that shares one single-address-bus 1K×8 RAM between two requesters. In the multiwatch, port A is the lap-record writer and port B is the display/readback path. The block drives the RAM's `wr_rd`, `addr` and `i_data` inputs and returns the RAM's registered `o_data` to whichever requester issued the read. The RAM is the one-address-bus variant: it writes when `wr_rd`=1 and registers its read data on the clock edge when `wr_rd`=0.

---
 rtl/ram_arbiter_rr.sv | 162 ++++++++++++++++
 tb/tb_ram_arbiter_rr.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_rr.sv
// ram_arbiter_rr: shares one single-address-bus RAM between two requesters.
// Port A and port B request accesses with req_x and hold them until gnt_x.
// The winner is chosen round-robin, or fixed A-first when the macro
// RAM_ARB_FIXED_PRIO_EN is defined.
//
// Ports:
//   clk, reset_p              clock and synchronous active-high reset
//   req_x, wr_rd_x            request and direction (1 = write)
//   addr_x, wdata_x           request address and write data
//   gnt_x                     one-cycle pulse while the command is at the RAM
//   rvalid_x, rdata_x         read-data pulse and hold register
//   busy                      high while an access is in flight
//   ram_wr_rd, ram_addr,
//   ram_i_data                registered RAM command
//   ram_o_data                registered RAM read data

module ram_arbiter_rr #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_p,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          wr_rd_a,
    input  logic          wr_rd_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          busy,
    output logic          ram_wr_rd,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_i_data,
    input  logic [DW-1:0] ram_o_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RDATA
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_grant;
    logic          w_win_b;
    logic          w_req_any;

    logic          r_prio_b;
    logic          r_owner_b;
    logic          r_gnt_a;
    logic          r_gnt_b;
    logic          r_rvalid_a;
    logic          r_rvalid_b;
    logic [DW-1:0] r_rdata_a;
    logic [DW-1:0] r_rdata_b;
    logic          r_ram_wr_rd;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_i_data;

    assign w_req_any = req_a | req_b;

    // B wins when it is the only requester, or when both request and the
    // pointer names B. In the fixed build the pointer never leaves A.
    assign w_win_b = req_b & (~req_a | r_prio_b);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            // r_ram_wr_rd still holds the direction of the issued command.
            ST_ISSUE: w_state_nxt = r_ram_wr_rd ? ST_IDLE : ST_RDATA;
            ST_RDATA: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_prio_b     <= 1'b0;
            r_owner_b    <= 1'b0;
            r_gnt_a      <= 1'b0;
            r_gnt_b      <= 1'b0;
            r_rvalid_a   <= 1'b0;
            r_rvalid_b   <= 1'b0;
            r_rdata_a    <= '0;
            r_rdata_b    <= '0;
            r_ram_wr_rd  <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_i_data <= '0;
        end else begin
            // Pulses and the write strobe default low; only a grant raises
            // them, so the RAM is never written outside an ISSUE cycle.
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
            r_ram_wr_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_gnt_a      <= ~w_win_b;
                        r_gnt_b      <= w_win_b;
                        r_owner_b    <= w_win_b;
                        r_ram_wr_rd  <= w_win_b ? wr_rd_b : wr_rd_a;
                        r_ram_addr   <= w_win_b ? addr_b : addr_a;
                        r_ram_i_data <= w_win_b ? wdata_b : wdata_a;
`ifdef RAM_ARB_FIXED_PRIO_EN
                        r_prio_b     <= 1'b0;
`else
                        // Pointer moves to the port that lost this round.
                        r_prio_b     <= ~w_win_b;
`endif
                    end
                end
                ST_RDATA: begin
                    if (r_owner_b) begin
                        r_rdata_b  <= ram_o_data;
                        r_rvalid_b <= 1'b1;
                    end else begin
                        r_rdata_a  <= ram_o_data;
                        r_rvalid_a <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt_a      = r_gnt_a;
    assign gnt_b      = r_gnt_b;
    assign rvalid_a   = r_rvalid_a;
    assign rvalid_b   = r_rvalid_b;
    assign rdata_a    = r_rdata_a;
    assign rdata_b    = r_rdata_b;
    assign busy       = (r_state != ST_IDLE);
    assign ram_wr_rd  = r_ram_wr_rd;
    assign ram_addr   = r_ram_addr;
    assign ram_i_data = r_ram_i_data;

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Testbench for ram_arbiter_rr: two requester drivers, a behavioural
// 1Kx8 RAM, and a negedge monitor comparing against a reference model.

module tb_ram_arbiter_rr;

    typedef struct {
        bit       wr;
        bit [9:0] addr;
        bit [7:0] data;
        int       gap;
    } cmd_t;

    logic       clk;
    logic       reset_p;
    logic       req_a, req_b, wr_rd_a, wr_rd_b;
    logic [9:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
    logic [7:0] rdata_a, rdata_b;
    logic       ram_wr_rd;
    logic [9:0] ram_addr;
    logic [7:0] ram_i_data, ram_o_data;

    ram_arbiter_rr #(.AW(10), .DW(8)) dut (
        .clk(clk), .reset_p(reset_p),
        .req_a(req_a), .req_b(req_b),
        .wr_rd_a(wr_rd_a), .wr_rd_b(wr_rd_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .busy(busy), .ram_wr_rd(ram_wr_rd),
        .ram_addr(ram_addr), .ram_i_data(ram_i_data),
        .ram_o_data(ram_o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-address-bus RAM.
    logic [7:0] ram_mem [1024];
    always @(posedge clk) begin
        if (ram_wr_rd) ram_mem[ram_addr] <= ram_i_data;
        else ram_o_data <= ram_mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input bit wr, input bit [9:0] a,
                                input bit [7:0] d, input int g);
        cmd_t c;
        c.wr = wr; c.addr = a; c.data = d; c.gap = g;
        return c;
    endfunction

    cmd_t stim_a[$], stim_b[$];
    cmd_t exp_cmd_a[$], exp_cmd_b[$];
    bit [7:0] exp_rd_a[$], exp_rd_b[$];
    bit   log_port[$];
    int   log_cyc[$];

    // Reference model: memory image, priority pointer, pending timers.
    bit [7:0] m_mem [1024];
    bit       m_prio_b;
    int       m_blk;
    int       rv_a, rv_b;
    bit [7:0] m_rd_a, m_rd_b;
    bit       s_rst = 1'b1;
    bit       p_a, p_b;
    int       cyc = 0;

    bit       r, dec, eg, wb, exa, exb;
    int       blk_old, was;
    cmd_t     mc;

    always @(negedge clk) begin
        cyc++;
        r = s_rst;
        s_rst = reset_p;
        if (r) begin
            m_prio_b = 1'b0; m_blk = 0; rv_a = 0; rv_b = 0;
            m_rd_a = 8'h00; m_rd_b = 8'h00;
            exp_rd_a.delete(); exp_rd_b.delete();
            chk("rst_gnt", {gnt_a, gnt_b}, 0);
            chk("rst_rvalid", {rvalid_a, rvalid_b}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ram_wr_rd", ram_wr_rd, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_i_data", ram_i_data, 0);
            chk("rst_rdata", {rdata_a, rdata_b}, 0);
        end else begin
            // Read-data return, two edges after the read grant.
            was = rv_a; if (rv_a > 0) rv_a--;
            exa = (was == 1);
            chk("rvalid_a", rvalid_a, exa);
            if (exa) begin
                if (exp_rd_a.size() > 0) m_rd_a = exp_rd_a.pop_front();
                else chk("rd_a_underflow", 0, 1);
            end
            was = rv_b; if (rv_b > 0) rv_b--;
            exb = (was == 1);
            chk("rvalid_b", rvalid_b, exb);
            if (exb) begin
                if (exp_rd_b.size() > 0) m_rd_b = exp_rd_b.pop_front();
                else chk("rd_b_underflow", 0, 1);
            end
            chk("rdata_a", rdata_a, m_rd_a);
            chk("rdata_b", rdata_b, m_rd_b);

            // Arbitration decision made at the edge just passed.
            blk_old = m_blk;
            dec = (m_blk == 0);
            if (m_blk > 0) m_blk--;
            eg = dec && (p_a || p_b);
`ifdef RAM_ARB_FIXED_PRIO_EN
            wb = p_b && !p_a;
`else
            wb = p_b && (!p_a || m_prio_b);
`endif
            chk("gnt_a", gnt_a, eg && !wb);
            chk("gnt_b", gnt_b, eg && wb);
            chk("busy", busy, eg || (blk_old == 2));
            if (eg) begin
                if ((wb ? exp_cmd_b.size() : exp_cmd_a.size()) == 0) begin
                    chk("cmd_underflow", 0, 1);
                end else begin
                    mc = wb ? exp_cmd_b.pop_front() : exp_cmd_a.pop_front();
                    chk("ram_wr_rd", ram_wr_rd, mc.wr);
                    chk("ram_addr", ram_addr, mc.addr);
                    if (mc.wr) begin
                        chk("ram_i_data", ram_i_data, mc.data);
                        m_mem[mc.addr] = mc.data;
                        m_blk = 1;
                    end else begin
                        if (wb) begin
                            exp_rd_b.push_back(m_mem[mc.addr]); rv_b = 2;
                        end else begin
                            exp_rd_a.push_back(m_mem[mc.addr]); rv_a = 2;
                        end
                        m_blk = 2;
                    end
`ifndef RAM_ARB_FIXED_PRIO_EN
                    m_prio_b = !wb;
`endif
                end
            end else begin
                chk("ram_wr_rd_idle", ram_wr_rd, 0);
            end
        end
        if (gnt_a) begin log_port.push_back(1'b0); log_cyc.push_back(cyc); end
        if (gnt_b) begin log_port.push_back(1'b1); log_cyc.push_back(cyc); end
        p_a = req_a;
        p_b = req_b;
    end

    task automatic run_port(input bit pb);
        cmd_t c;
        bit   got;
        while ((pb ? stim_b.size() : stim_a.size()) != 0) begin
            c = pb ? stim_b.pop_front() : stim_a.pop_front();
            if (pb) begin
                exp_cmd_b.push_back(c);
                wr_rd_b = c.wr; addr_b = c.addr; wdata_b = c.data; req_b = 1'b1;
            end else begin
                exp_cmd_a.push_back(c);
                wr_rd_a = c.wr; addr_a = c.addr; wdata_a = c.data; req_a = 1'b1;
            end
            got = 1'b0;
            for (int k = 0; k < 200 && !got; k++) begin
                @(posedge clk); #1;
                got = pb ? gnt_b : gnt_a;
            end
            chk(pb ? "gnt_b_wait" : "gnt_a_wait", got, 1);
            if (!got) begin
                if (pb) stim_b.delete(); else stim_a.delete();
            end
            if (!got || c.gap > 0 ||
                (pb ? stim_b.size() : stim_a.size()) == 0) begin
                if (pb) req_b = 1'b0; else req_a = 1'b0;
            end
            if (c.gap > 0) begin
                repeat (c.gap) @(posedge clk);
                #1;
            end
        end
        if (pb) req_b = 1'b0; else req_a = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(6);
        reset_p = 1'b1;
        idle(1);
        reset_p = 1'b0;
    endtask

    int na, nb;
    bit got;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = 8'h00;
            m_mem[i] = 8'h00;
        end
        ram_o_data = 8'h00;
        reset_p = 1'b1;
        req_a = 1'b1; req_b = 1'b0;
        wr_rd_a = 1'b1; wr_rd_b = 1'b0;
        addr_a = 10'h001; addr_b = '0;
        wdata_a = 8'h5A; wdata_b = '0;

        // Reset held with A requesting.
        repeat (2) @(posedge clk);
        #1;
        req_a = 1'b0;
        reset_p = 1'b0;

        // Write then read on A at the top address.
        stim_a.push_back(mk(1'b1, 10'h3FF, 8'hA5, 0));
        stim_a.push_back(mk(1'b0, 10'h3FF, 8'h00, 0));
        run_port(1'b0);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            got = rvalid_a;
        end
        chk("t2_rvalid_seen", got, 1);
        chk("t2_rdata_a", rdata_a, 8'hA5);

        // Simultaneous writes straight after reset.
        do_reset();
        log_port.delete(); log_cyc.delete();
        stim_a.push_back(mk(1'b1, 10'd5, 8'h11, 0));
        stim_b.push_back(mk(1'b1, 10'd6, 8'h22, 0));
        fork
            run_port(1'b0);
            run_port(1'b1);
        join
        idle(4);
        chk("t3_ngrants", log_port.size(), 2);
        if (log_port.size() >= 2) begin
            chk("t3_first_a", log_port[0], 0);
            chk("t3_second_b", log_port[1], 1);
            chk("t3_gap", log_cyc[1] - log_cyc[0], 2);
        end
        chk("t3_mem5", ram_mem[5], 8'h11);
        chk("t3_mem6", ram_mem[6], 8'h22);

        // Saturation with reads.
        do_reset();
        log_port.delete(); log_cyc.delete();
`ifdef RAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 20; i++)
            stim_a.push_back(mk(1'b0, 10'($urandom_range(0, 15)), 8'h00, 0));
        stim_b.push_back(mk(1'b0, 10'd6, 8'h00, 0));
`else
        for (int i = 0; i < 10; i++) begin
            stim_a.push_back(mk(1'b0, 10'($urandom_range(0, 15)), 8'h00, 0));
            stim_b.push_back(mk(1'b0, 10'($urandom_range(0, 15)), 8'h00, 0));
        end
`endif
        fork
            run_port(1'b0);
            run_port(1'b1);
        join
        idle(6);
        chk("t4_ngrants_ge20", log_port.size() >= 20, 1);
        na = 0; nb = 0;
        for (int i = 0; i < 20 && i < log_port.size(); i++) begin
            if (log_port[i]) nb++; else na++;
`ifndef RAM_ARB_FIXED_PRIO_EN
            chk("t4_alternate", log_port[i], i % 2);
`endif
        end
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk("t4_count_a", na, 20);
        chk("t4_count_b", nb, 0);
`else
        chk("t4_count_a", na, 10);
        chk("t4_count_b", nb, 10);
`endif

        // Reset while a B read is in its RDATA cycle.
        do_reset();
        stim_b.push_back(mk(1'b0, 10'd6, 8'h00, 0));
        run_port(1'b1);
        idle(1);
        reset_p = 1'b1;
        idle(1);
        reset_p = 1'b0;
        chk("t5_rdata_b", rdata_b, 0);
        chk("t5_rvalid_b", rvalid_b, 0);
        chk("t5_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("t5_no_rvalid_b", rvalid_b, 0);
        end
        stim_a.push_back(mk(1'b1, 10'd7, 8'($urandom), 0));
        stim_a.push_back(mk(1'b0, 10'd7, 8'h00, 0));
        run_port(1'b0);
        idle(6);

        // Random mixed traffic from both ports.
        for (int i = 0; i < 30; i++) begin
            stim_a.push_back(mk(1'($urandom), 10'($urandom_range(0, 15)),
                                8'($urandom), $urandom_range(0, 3)));
            stim_b.push_back(mk(1'($urandom), 10'($urandom_range(0, 15)),
                                8'($urandom), $urandom_range(0, 3)));
        end
        fork
            run_port(1'b0);
            run_port(1'b1);
        join
        idle(8);
        chk("rd_a_drained", exp_rd_a.size(), 0);
        chk("rd_b_drained", exp_rd_b.size(), 0);
        for (int i = 0; i < 16; i++) chk("mem_image", ram_mem[i], m_mem[i]);
        chk("mem_3ff", ram_mem[10'h3FF], 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
